// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared direction/mode constants and terminal-value helper
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Value at which a counter of the given modulus stops or wraps in direction up.
  function automatic int unsigned term_value(input logic up, input int unsigned modulus);
    return (up == DIR_UP) ? modulus - 1 : 0;
  endfunction

endpackage

// File: rtl/count_step.sv
// rtl/count_step.sv - combinational next-count, terminal and wrap detection
module count_step
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  input  logic             sat,
  output logic [WIDTH-1:0] q_next,
  output logic             term,
  output logic             wrap_evt
);

  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MODULUS - 1);

  // One extra bit keeps MODULUS = 2**WIDTH from aliasing MODULUS-1 with -1.
  logic [WIDTH:0] q_ext;
  logic [WIDTH:0] term_ext;
  logic [WIDTH:0] q_next_ext;
  logic           unused_msb;

  assign q_ext    = {1'b0, q};
  assign term_ext = (WIDTH+1)'(term_value(up, MODULUS));
  assign term     = (q_ext == term_ext);

  always_comb begin
    q_next_ext = q_ext;
    wrap_evt   = 1'b0;
    if (!term) begin
      q_next_ext = (up == DIR_UP) ? q_ext + (WIDTH+1)'(1) : q_ext - (WIDTH+1)'(1);
    end else if (sat != MODE_SAT) begin
      q_next_ext = (up == DIR_UP) ? '0 : MAX_EXT;
      wrap_evt   = 1'b1;
    end
  end

  assign q_next     = q_next_ext[WIDTH-1:0];
  assign unused_msb = q_next_ext[WIDTH];

endmodule

// File: rtl/updown_counter.sv
// rtl/updown_counter.sv - loadable, cascadable up/down counter with wrap/saturate modes
module updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cin,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             wrapped,
  output logic             load_err
);

  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrapped_q, wrapped_d;
  logic             load_err_q, load_err_d;
  logic [WIDTH-1:0] q_next;
  logic             term;
  logic             wrap_evt;
  logic             step;
  logic             load_oor;

  count_step #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_step (
    .q        (q_q),
    .up       (up),
    .sat      (sat),
    .q_next   (q_next),
    .term     (term),
    .wrap_evt (wrap_evt)
  );

  assign step     = en & cin & ~load;
  assign load_oor = ({1'b0, load_val} > MAX_EXT);

  always_comb begin
    q_d        = q_q;
    wrapped_d  = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      q_d        = load_oor ? MAX_EXT[WIDTH-1:0] : load_val;
      load_err_d = load_oor;
    end else if (step) begin
      q_d       = q_next;
      wrapped_d = wrap_evt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q        <= '0;
      wrapped_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      wrapped_q  <= wrapped_d;
      load_err_q <= load_err_d;
    end
  end

  // Next stage advances on the edge where this one wraps; saturating stages never carry.
  assign cout     = en & cin & term & ~sat & ~load;
  assign q        = q_q;
  assign wrapped  = wrapped_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_updown_counter.sv
// tb/tb_updown_counter.sv - scoreboard bench for updown_counter (mod 10, mod 16 cascade, mod 2)
module tb_updown_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0, en = 1'b0, up = 1'b0, sat = 1'b0, load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] a_q, lo_q, hi_q, m_q;
  logic       a_co, a_w, a_le;
  logic       lo_co, lo_w, lo_le, hi_co, hi_w, hi_le;
  logic       m_co, m_w, m_le;

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .reset(reset), .en(en), .cin(1'b1), .up(up), .sat(sat), .load(load),
    .load_val(load_val), .q(a_q), .cout(a_co), .wrapped(a_w), .load_err(a_le));

  updown_counter #(.WIDTH(4), .MODULUS(16)) u_lo (
    .clk(clk), .reset(reset), .en(en), .cin(1'b1), .up(up), .sat(sat), .load(load),
    .load_val(load_val), .q(lo_q), .cout(lo_co), .wrapped(lo_w), .load_err(lo_le));

  updown_counter #(.WIDTH(4), .MODULUS(16)) u_hi (
    .clk(clk), .reset(reset), .en(en), .cin(lo_co), .up(up), .sat(sat), .load(load),
    .load_val(load_val), .q(hi_q), .cout(hi_co), .wrapped(hi_w), .load_err(hi_le));

  updown_counter #(.WIDTH(4), .MODULUS(2)) u_m2 (
    .clk(clk), .reset(reset), .en(en), .cin(1'b1), .up(up), .sat(sat), .load(load),
    .load_val(load_val), .q(m_q), .cout(m_co), .wrapped(m_w), .load_err(m_le));

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] q;
    logic       w;
    logic       le;
    logic       co;
  } exp_t;

  exp_t sb[$];
  exp_t mx;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] act_q;
  logic       act_w, act_le, act_co;

  // Inputs change on the falling edge; the entry describes outputs after the next rising edge.
  task automatic step(input string name, input int sel, input logic r, input logic ld,
                      input logic [3:0] lv, input logic e, input logic u, input logic s,
                      input logic [7:0] eq, input logic ew, input logic ele, input logic eco);
    exp_t x;
    @(negedge clk);
    reset = r; load = ld; load_val = lv; en = e; up = u; sat = s;
    x.name = name; x.sel = sel; x.q = eq; x.w = ew; x.le = ele; x.co = eco;
    sb.push_back(x);
  endtask

  always begin
    @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      mx = sb.pop_front();
      case (mx.sel)
        1:       begin act_q = {hi_q, lo_q}; act_w = lo_w; act_le = lo_le; act_co = lo_co; end
        2:       begin act_q = {4'd0, m_q};  act_w = m_w;  act_le = m_le;  act_co = m_co;  end
        default: begin act_q = {4'd0, a_q};  act_w = a_w;  act_le = a_le;  act_co = a_co;  end
      endcase
      checks++;
      if ({act_q, act_w, act_le, act_co} !== {mx.q, mx.w, mx.le, mx.co}) begin
        errors++;
        $display("FAIL %s: got q=%h wrapped=%b load_err=%b cout=%b, want q=%h wrapped=%b load_err=%b cout=%b",
                 mx.name, act_q, act_w, act_le, act_co, mx.q, mx.w, mx.le, mx.co);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    //     name            sel r ld lv e u s  q      w le co
    step("rst_a",          0, 1, 1, 9, 1, 1, 0, 8'h0, 0, 0, 0);
    step("rst_casc",       1, 1, 1, 9, 1, 1, 0, 8'h0, 0, 0, 0);
    step("rst_m2",         2, 1, 1, 9, 1, 1, 0, 8'h0, 0, 0, 0);

    step("dn_load2",       0, 0, 1, 2, 0, 0, 0, 8'h2, 0, 0, 0);
    step("dn_1",           0, 0, 0, 0, 1, 0, 0, 8'h1, 0, 0, 0);
    step("dn_0",           0, 0, 0, 0, 1, 0, 0, 8'h0, 0, 0, 1);
    step("dn_wrap9",       0, 0, 0, 0, 1, 0, 0, 8'h9, 1, 0, 0);
    step("dn_8",           0, 0, 0, 0, 1, 0, 0, 8'h8, 0, 0, 0);

    step("sat_load8",      0, 0, 1, 8, 0, 1, 1, 8'h8, 0, 0, 0);
    step("sat_9a",         0, 0, 0, 0, 1, 1, 1, 8'h9, 0, 0, 0);
    step("sat_9b",         0, 0, 0, 0, 1, 1, 1, 8'h9, 0, 0, 0);
    step("sat_9c",         0, 0, 0, 0, 1, 1, 1, 8'h9, 0, 0, 0);

    step("oor_load13",     0, 0, 1, 13, 0, 1, 0, 8'h9, 0, 1, 0);
    step("oor_pulse_end",  0, 0, 0, 0, 0, 1, 0, 8'h9, 0, 0, 0);
    step("load_beats_en",  0, 0, 1, 5, 1, 1, 0, 8'h5, 0, 0, 0);

    step("flip_up6",       0, 0, 0, 0, 1, 1, 0, 8'h6, 0, 0, 0);
    step("flip_dn5",       0, 0, 0, 0, 1, 0, 0, 8'h5, 0, 0, 0);
    step("flip_up6b",      0, 0, 0, 0, 1, 1, 0, 8'h6, 0, 0, 0);
    step("flip_dn5b",      0, 0, 0, 0, 1, 0, 0, 8'h5, 0, 0, 0);
    step("to_6",           0, 0, 0, 0, 1, 1, 0, 8'h6, 0, 0, 0);
    step("to_7",           0, 0, 0, 0, 1, 1, 0, 8'h7, 0, 0, 0);
    step("rst_midcount",   0, 1, 0, 0, 1, 1, 0, 8'h0, 0, 0, 0);

    step("up_load9",       0, 0, 1, 9, 0, 1, 0, 8'h9, 0, 0, 0);
    step("up_wrap0",       0, 0, 0, 0, 1, 1, 0, 8'h0, 1, 0, 0);

    step("casc_load0",     1, 0, 1, 0, 0, 1, 0, 8'h00, 0, 0, 0);
    for (int k = 1; k <= 16; k++)
      step("casc_up",      1, 0, 0, 0, 1, 1, 0, 8'(k), (k == 16), 0, (k == 15));
    step("casc_borrow",    1, 0, 0, 0, 1, 0, 0, 8'h0F, 1, 0, 0);

    step("m2_load0",       2, 0, 1, 0, 0, 1, 0, 8'h0, 0, 0, 0);
    step("m2_up1",         2, 0, 0, 0, 1, 1, 0, 8'h1, 0, 0, 1);
    step("m2_up0",         2, 0, 0, 0, 1, 1, 0, 8'h0, 1, 0, 0);
    step("m2_up1b",        2, 0, 0, 0, 1, 1, 0, 8'h1, 0, 0, 1);
    step("m2_up0b",        2, 0, 0, 0, 1, 1, 0, 8'h0, 1, 0, 0);
    step("m2_dn1",         2, 0, 0, 0, 1, 0, 0, 8'h1, 1, 0, 0);
    step("m2_dn0",         2, 0, 0, 0, 1, 0, 0, 8'h0, 0, 0, 1);
    step("m2_load_oor",    2, 0, 1, 3, 0, 1, 0, 8'h1, 0, 1, 0);
    step("m2_sat_dn0",     2, 0, 0, 0, 1, 0, 1, 8'h0, 0, 0, 0);
    step("m2_sat_hold",    2, 0, 0, 0, 1, 0, 1, 8'h0, 0, 0, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_counter.md
# updown_counter

Synchronous, loadable, cascadable up/down counter of configurable width and modulus. It is the down-counting, fully synchronous counterpart of the team's ripple up-counter, used for countdown timers and bidirectional position tracking. A carry/borrow chain (`cin`/`cout`) lets several instances be chained into wider counters without ripple delay between stages.

## Interface
- `WIDTH`, default 4: counter width in bits.
- `MODULUS`, default 16: count range is 0 to MODULUS-1. Legal range is 2 ≤ MODULUS ≤ 2^WIDTH.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  count enable.
- `cin`  in  1  cascade enable from the lower stage. Tie to 1 on the least-significant stage.
- `up`  in  1  direction: 1 = up, 0 = down.
- `sat`  in  1  terminal behaviour: 1 = saturate, 0 = wrap.
- `load`  in  1  synchronous parallel load.
- `load_val`  in  WIDTH  value to load.
- `q`  out  WIDTH  current count, registered.
- `cout`  out  1  combinational carry/borrow to the next stage.
- `wrapped`  out  1  registered one-cycle pulse marking a wrap event.
- `load_err`  out  1  registered one-cycle pulse marking an out-of-range load.

## Operation
- One clock; reset is synchronous and active-high (ports `clk`, `reset`).
- Priority on each rising edge: `reset` > `load` > count > hold.
- **Reset:** `q`=0, `wrapped`=0, `load_err`=0.
- **Load:** if `load_val` ≤ MODULUS-1, then `q`←`load_val` and `load_err`←0. Otherwise `q`←MODULUS-1 (clamped) and `load_err`←1. A load ignores `en` and `cin`.
- **Count condition:** `step` = `en` & `cin` & ~`load`.
- **Up count (`up`=1):**
  - If `q` < MODULUS-1: `q`←`q`+1.
  - If `q` = MODULUS-1 and `sat`=0: `q`←0 and `wrapped`←1.
  - If `q` = MODULUS-1 and `sat`=1: hold.
- **Down count (`up`=0):**
  - If `q` > 0: `q`←`q`-1.
  - If `q` = 0 and `sat`=0: `q`←MODULUS-1 and `wrapped`←1.
  - If `q` = 0 and `sat`=1: hold.
- **Pulse outputs:** `wrapped` and `load_err` are 0 in every cycle that does not set them.
- **Terminal value:** `term` = (`up` ? `q`==MODULUS-1 : `q`==0).
- **Carry out:** `cout` = `en` & `cin` & `term` & ~`sat` & ~`load`. This is a pure function of the current inputs and `q`; it does not depend on reset.
- **Arithmetic width:** next-state arithmetic is computed at WIDTH+1 bits so that MODULUS = 2^WIDTH wraps correctly. `q` never holds a value ≥ MODULUS.
- **Direction change:** changing `up` mid-count takes effect on the same edge. There is no pipeline state.

## Timing
- Latency from `load` or a count step to a new `q`: one cycle.
- `wrapped` and `load_err` assert in the same cycle as the `q` update that caused them, and last exactly one cycle.
- `cout` is valid in the same cycle as its inputs. Across a cascade, stage N advances on the same edge on which stage N-1 wraps.
- **Reset with other controls:** reset asserted together with `load` or `en` results in `q`=0. Reset mid-count discards the in-flight step.
- **Load with count:** simultaneous `load` and `en` loads; no count occurs and no `wrapped` pulse is produced.
- **Wrap boundaries:**
  - Up wrap from MODULUS-1 goes to 0 in a single cycle.
  - Down wrap from 0 goes to MODULUS-1 in a single cycle.
  - With MODULUS=2, the counter alternates 0,1,0,1 and `wrapped` asserts on every 1→0 (up) or 0→1 (down) transition.

## Structure
- Shared package `counter_pkg`:
  - `DIR_UP`=1, `DIR_DOWN`=0.
  - `MODE_WRAP`=0, `MODE_SAT`=1.
  - A function returning the terminal value for a given direction and modulus.
- Sub-module `count_step`: a combinational next-state block taking `q`, `up`, `sat`, and MODULUS, and producing `q_next`, `term`, and `wrap_evt`.
- The top level holds the registers, load clamping, priority logic, and `cout`.

## Test plan
1. **Reset:** reset for 2 cycles with `en`=1 and `load`=1, `load_val`=9 → `q`=0, `wrapped`=0, `load_err`=0.
2. **Down wrap (WIDTH=4, MODULUS=10):** load 2, then `up`=0, `sat`=0, `en`=1 for 4 cycles → `q` = 1, 0, 9, 8. `wrapped` pulses on the 0→9 edge only. `cout`=1 only while `q`=0.
3. **Saturation:** load 8, `up`=1, `sat`=1, `en`=1 for 3 cycles → `q` = 9, 9, 9. `wrapped` and `cout` stay 0.
4. **Out-of-range load (MODULUS=10):** `load_val`=13 → `q`=9, `load_err`=1 for one cycle, then 0. Simultaneous `load`=1, `en`=1, `load_val`=5 → `q`=5 with no step.
5. **Cascade:** two 4-bit stages with MODULUS=16, low `cout` driving high `cin`, starting at 0x00 and counting up → after 16 steps the pair reads 0x10. Then counting down 1 step → 0x0F, with borrow on the same edge.
6. **Direction flip and reset mid-count:** `q`=5, toggle `up` each cycle for 4 cycles → 6, 5, 6, 5. Assert reset while `q`=7 with `en`=1 → `q`=0 on the next edge.
